// File: rtl/sm_hex_scan.sv
// sm_hex_scan: time-multiplexed driver for a common-anode 7-segment array.
// A prescaler divides the board clock into digit slots. A digit index walks
// 0..DIGITS-1, one digit per slot. The value to show is latched once per
// frame, at the wrap back to digit 0, so a frame never mixes two values.
// Every output comes straight from a flop.
module sm_hex_scan #(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 1000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dpMask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frameDone
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Scan position and per-frame snapshot
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [4*DIGITS-1:0]  r_snap;
  logic [DIGITS-1:0]    r_dp_snap;
  logic                 r_frame_done;

  // Registered display outputs
  logic [DIGITS-1:0]    r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  // Next-slot decode
  logic                 w_tick;
  logic                 w_wrap;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [4*DIGITS-1:0]  w_snap_use;
  logic [DIGITS-1:0]    w_dp_use;
  logic [4*DIGITS-1:0]  w_upper;
  logic [DIGITS-1:0]    w_dp_shift;
  logic                 w_dp_req;
  logic                 w_blank;
  logic [DIGITS-1:0]    w_an_sel;
  logic [6:0]           w_seg_nib;

  // Hex glyphs, active low, bit order {g,f,e,d,c,b,a}; b and d are lower case
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Work out the slot boundary, the next digit, and how that digit looks.
  // At the wrap tick the incoming data feeds digit 0 directly. This means
  // the new frame starts on the same edge that latches it.
  always_comb begin
    w_tick     = enable && (r_cnt == CNT_LAST);
    w_wrap     = w_tick && (r_idx == IDX_LAST);
    w_cnt_nxt  = (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt  = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    w_snap_use = w_wrap ? data   : r_snap;
    w_dp_use   = w_wrap ? dpMask : r_dp_snap;
    // Shifting the snapshot down by the digit position gives two things at
    // once. The low nibble is the glyph to draw. The whole shifted value is
    // zero exactly when this digit and everything to its left are zero.
    w_upper    = w_snap_use >> {w_idx_nxt, 2'b00};
    w_dp_shift = w_dp_use >> w_idx_nxt;
    w_dp_req   = w_dp_shift[0];
    w_blank    = BLANK_ZEROS && (w_idx_nxt != '0) && (w_upper == '0) && !w_dp_req;
    w_an_sel   = DIGITS'(1) << w_idx_nxt;
    w_seg_nib  = hex_to_seg(w_upper[3:0]);
  end

  // Prescaler, digit index and frame snapshot; all frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_snap       <= '0;
      r_dp_snap    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (enable) begin
        r_cnt <= w_cnt_nxt;
        if (w_tick) begin
          r_idx <= w_idx_nxt;
        end
        if (w_wrap) begin
          r_snap       <= data;
          r_dp_snap    <= dpMask;
          r_frame_done <= 1'b1;
        end
      end
    end
  end

  // Drive the anode, segments and dp. Go dark while disabled, and hold
  // the current digit between ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= SEG_DARK;
      r_dp  <= 1'b1;
    end else if (!enable) begin
      r_an  <= '1;
      r_seg <= SEG_DARK;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      if (w_blank) begin
        r_an  <= '1;
        r_seg <= SEG_DARK;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~w_an_sel;
        r_seg <= w_seg_nib;
        r_dp  <= ~w_dp_req;
      end
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign frameDone = r_frame_done;

endmodule

// File: tb/tb_sm_hex_scan.sv
// Testbench for sm_hex_scan (DIGITS=8, SCAN_DIV=4, BLANK_ZEROS=1).
// A reference model predicts every output on every cycle. It works from
// counts of enabled cycles and ticks, using plain arithmetic. A vector
// table and a few directed sequences cover the listed scenarios.
module tb_sm_hex_scan;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] data;
  logic [7:0]  dpMask;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frameDone;

  sm_hex_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_ZEROS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data), .dpMask(dpMask),
    .seg(seg), .dp(dp), .an(an), .frameDone(frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint     m_en_cycles;
  int         m_idx;
  logic [31:0] m_snap;
  logic [7:0]  m_dpsnap;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic        m_fd;

  logic [6:0] glyph [16];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dpm;
    logic [63:0] an_all;
    logic [55:0] seg_all;
    logic [7:0]  dp_all;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en_cycles = 0;
    m_idx       = 0;
    m_snap      = '0;
    m_dpsnap    = '0;
    m_an        = 8'hFF;
    m_seg       = 7'h7F;
    m_dp        = 1'b1;
    m_fd        = 1'b0;
  endtask

  // Predict the outputs after the coming rising edge from the current inputs
  task automatic model_edge();
    longint upper;
    int     k;
    int     n;
    bit     tick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_fd = 1'b0;
    if (!enable) begin
      m_an  = 8'hFF;
      m_seg = 7'h7F;
      m_dp  = 1'b1;
      return;
    end
    tick = ((m_en_cycles % SCAN_DIV) == SCAN_DIV - 1);
    m_en_cycles++;
    if (tick) begin
      k     = int'(m_en_cycles / SCAN_DIV);
      n     = k % DIGITS;
      m_idx = n;
      if (n == 0) begin
        m_snap   = data;
        m_dpsnap = dpMask;
        m_fd     = 1'b1;
      end
      upper = longint'(m_snap) >> (4 * n);
      if (n != 0 && upper == 0 && m_dpsnap[n] == 1'b0) begin
        m_an  = 8'hFF;
        m_seg = 7'h7F;
        m_dp  = 1'b1;
      end else begin
        m_an  = ~(8'h01 << n);
        m_seg = glyph[int'(upper % 16)];
        m_dp  = ~m_dpsnap[n];
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_an", an, m_an);
    chk("model_seg", seg, m_seg);
    chk("model_dp", dp, m_dp);
    chk("model_frameDone", frameDone, m_fd);
  endtask

  task automatic wait_frame();
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!m_fd && i < 200);
    chk("wait_frame_timeout", m_fd, 1'b1);
  endtask

  task automatic wait_state(input int ti, input int tc);
    int  i;
    bit  hit;
    hit = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (m_idx == ti && (m_en_cycles % SCAN_DIV) == tc) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    chk("wait_state_timeout", hit, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_fd;
    int second_fd;
    int cyc;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    tbl[0] = '{32'h12345678, 8'h00, 64'h7FBFDFEFF7FBFDFE,
               {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,7'h00}, 8'hFF};
    tbl[1] = '{32'h000000A0, 8'h00, 64'hFFFFFFFFFFFFFDFE,
               {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h40}, 8'hFF};
    tbl[2] = '{32'h000000A0, 8'h10, 64'hFFFFFFEFFFFFFDFE,
               {7'h7F,7'h7F,7'h7F,7'h40,7'h7F,7'h7F,7'h08,7'h40}, 8'hEF};
    tbl[3] = '{32'h9ABCDEF0, 8'h01, 64'h7FBFDFEFF7FBFDFE,
               {7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E,7'h40}, 8'hFE};
    tbl[4] = '{32'h00000000, 8'h80, 64'h7FFFFFFFFFFFFFFE,
               {7'h40,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'h7F};
    tbl[5] = '{32'h00F00000, 8'h00, 64'hFFFFDFEFF7FBFDFE,
               {7'h7F,7'h7F,7'h0E,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hFF};

    // Reset held
    rst_n  = 1'b0;
    enable = 1'b1;
    data   = 32'h12345678;
    dpMask = 8'h00;
    model_reset();
    repeat (3) step();
    chk("reset_an", an, 8'hFF);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp", dp, 1'b1);
    chk("reset_frameDone", frameDone, 1'b0);

    // Release reset: frame period and first frame content
    @(negedge clk);
    rst_n     = 1'b1;
    first_fd  = -1;
    second_fd = -1;
    for (cyc = 1; cyc <= 100 && second_fd < 0; cyc++) begin
      step();
      if (frameDone === 1'b1) begin
        if (first_fd < 0) begin
          first_fd = cyc;
          chk("first_frame_digit0_seg", seg, 7'h00);
          chk("first_frame_digit0_an", an, 8'hFE);
        end else begin
          second_fd = cyc;
        end
      end
    end
    chk("first_frameDone_cycle", first_fd, 32);
    chk("frameDone_period", second_fd - first_fd, 32);

    // Vector table: each value fills one full frame, slot by slot
    for (int v = 0; v < 6; v++) begin
      data   = tbl[v].data;
      dpMask = tbl[v].dpm;
      wait_frame();
      for (int s = 0; s < DIGITS; s++) begin
        chk($sformatf("tbl%0d_slot%0d_an", v, s), an, tbl[v].an_all[s*8 +: 8]);
        chk($sformatf("tbl%0d_slot%0d_seg", v, s), seg, tbl[v].seg_all[s*7 +: 7]);
        chk($sformatf("tbl%0d_slot%0d_dp", v, s), dp, tbl[v].dp_all[s]);
        repeat (SCAN_DIV - 1) step();
        chk($sformatf("tbl%0d_slot%0d_hold_an", v, s), an, tbl[v].an_all[s*8 +: 8]);
        step();
      end
    end

    // Data changes mid-frame: the rest of the frame keeps the old snapshot
    data   = 32'h12345678;
    dpMask = 8'h00;
    wait_frame();
    wait_state(3, 0);
    data = 32'h9ABCDEF0;
    for (int s = 4; s < DIGITS; s++) begin
      repeat (SCAN_DIV) step();
      chk($sformatf("midframe_slot%0d_seg", s), seg, glyph[8 - s]);
    end
    repeat (SCAN_DIV) step();
    chk("midframe_new_frameDone", frameDone, 1'b1);
    chk("midframe_new_digit0_seg", seg, 7'h40);

    // Drop enable at idx=5, cnt=2 for 10 cycles
    wait_state(5, 2);
    enable = 1'b0;
    step();
    chk("disable_dark_an", an, 8'hFF);
    chk("disable_dark_seg", seg, 7'h7F);
    repeat (9) step();
    enable = 1'b1;
    step();
    chk("reenable_still_dark", an, 8'hFF);
    step();
    chk("reenable_tick_idx6_an", an, 8'hBF);
    chk("reenable_tick_idx6_seg", seg, 7'h08);

    // Asynchronous reset mid-scan at idx=6
    data   = 32'h0;
    dpMask = 8'h00;
    wait_state(6, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp", dp, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c < 32; c++) begin
      step();
      chk("post_rst_blank_an", an, 8'hFF);
    end
    step();
    chk("post_rst_frameDone", frameDone, 1'b1);
    chk("post_rst_digit0_an", an, 8'hFE);
    chk("post_rst_digit0_seg", seg, 7'h40);

    // Randomized traffic against the model
    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(0, 15) == 0) data = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) dpMask = 8'($urandom & $urandom & $urandom);
      enable = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
